config_stream_loader: RTL and testbench

Byte-stream configuration loader for the PE tile array. It accepts a byte stream over a valid/ready handshake and assembles address/data frames. It then drives the shared `config_addr`/`config_data` bus consumed by every tile's address matchers, connect boxes, CLB and switch box. It is the only writer of that bus and sits directly upstream of all tiles.

---
 rtl/config_stream_loader.sv | 163 ++++++++++++++++
 tb/tb_config_stream_loader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/config_stream_loader.sv
// Byte-stream configuration loader: assembles little-endian addr/data frames and drives the tile config bus.
// Optional build macro CFG_CHECKSUM_EN appends an XOR checksum byte to every frame and counts rejected frames.
module config_stream_loader #(
  parameter logic [31:0] IDLE_ADDR    = 32'h0000_0000,
  parameter int          WRITE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] config_addr,
  output logic [31:0] config_data,
  output logic        config_write,
  output logic        config_done,
  output logic [15:0] frame_count,
  output logic [7:0]  err_count
);

`ifdef CFG_CHECKSUM_EN
  localparam int             IDX_W    = 4;
  localparam int             DATA_W   = 32;
  localparam logic [IDX_W-1:0] LAST_IDX = 4'd8;
`else
  localparam int             IDX_W    = 3;
  localparam int             DATA_W   = 24;
  localparam logic [IDX_W-1:0] LAST_IDX = 3'd7;
`endif
  localparam logic [3:0] CNT_LOAD = 4'(WRITE_CYCLES - 1);

  typedef enum logic [1:0] {S_COLLECT, S_WRITE, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [IDX_W-1:0]    r_idx;
  logic [31:0]         r_addr;
  logic [DATA_W-1:0]   r_data;
  logic [3:0]          r_cnt;
  logic                r_in_ready, r_config_write, r_config_done;
  logic [31:0]         r_config_addr, r_config_data;
  logic [15:0]         r_frame_count;
  logic                w_xfer, w_last, w_csum_bad, w_enter_write;
  logic                w_ready_nxt, w_write_nxt, w_done_nxt;
  logic [31:0]         w_addr_nxt, w_data_full;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign w_xfer        = in_valid && r_in_ready;
  assign w_last        = w_xfer && (r_idx == LAST_IDX);
  assign w_enter_write = (r_state == S_COLLECT) && (w_state_nxt == S_WRITE);

`ifdef CFG_CHECKSUM_EN
  logic [7:0] r_csum;
  logic [7:0] r_err_count;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (w_xfer) r_csum <= (r_idx == '0) ? in_data : (r_csum ^ in_data);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          r_err_count <= 8'h00;
    else if (w_csum_bad) r_err_count <= sat_inc8(r_err_count);
  end

  assign w_csum_bad  = w_last && (in_data != r_csum);
  assign w_data_full = r_data;
  assign err_count   = r_err_count;
`else
  // Without a checksum byte, the final data byte arrives on the same edge the write is launched.
  assign w_csum_bad  = 1'b0;
  assign w_data_full = {in_data, r_data};
  assign err_count   = 8'h00;
`endif

  // Lane capture: bytes 0-3 address, 4-7 data, little-endian.
  always_ff @(posedge clk) begin
    if (w_xfer && !w_last) begin
      case (r_idx[2:0])
        3'd0: r_addr[7:0]    <= in_data;
        3'd1: r_addr[15:8]   <= in_data;
        3'd2: r_addr[23:16]  <= in_data;
        3'd3: r_addr[31:24]  <= in_data;
        3'd4: r_data[7:0]    <= in_data;
        3'd5: r_data[15:8]   <= in_data;
        3'd6: r_data[23:16]  <= in_data;
`ifdef CFG_CHECKSUM_EN
        3'd7: r_data[31:24]  <= in_data;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_COLLECT;
      r_idx   <= '0;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer) r_idx <= w_last ? '0 : r_idx + 1'b1;
      if (w_enter_write)                          r_cnt <= CNT_LOAD;
      else if (r_state == S_WRITE && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_COLLECT: begin
        if (w_last) begin
          if (w_csum_bad)                 w_state_nxt = S_COLLECT;
          else if (r_addr == 32'hFFFF_FFFF) w_state_nxt = S_DONE;
          else                            w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: if (r_cnt == 4'd0) w_state_nxt = S_COLLECT;
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_COLLECT;
    endcase
  end

  // Outputs are registered decodes of the next state, so they change on the same edge as the state.
  always_comb begin
    w_ready_nxt = (w_state_nxt == S_COLLECT);
    w_write_nxt = (w_state_nxt == S_WRITE);
    w_done_nxt  = (w_state_nxt == S_DONE);
    w_addr_nxt  = w_write_nxt ? r_addr : IDLE_ADDR;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_in_ready     <= 1'b0;
      r_config_write <= 1'b0;
      r_config_done  <= 1'b0;
      r_config_addr  <= IDLE_ADDR;
      r_config_data  <= 32'h0;
      r_frame_count  <= 16'h0;
    end else begin
      r_in_ready     <= w_ready_nxt;
      r_config_write <= w_write_nxt;
      r_config_done  <= w_done_nxt;
      r_config_addr  <= w_addr_nxt;
      if (w_enter_write) begin
        r_config_data <= w_data_full;
        r_frame_count <= sat_inc16(r_frame_count);
      end
    end
  end

  assign in_ready     = r_in_ready;
  assign config_write = r_config_write;
  assign config_done  = r_config_done;
  assign config_addr  = r_config_addr;
  assign config_data  = r_config_data;
  assign frame_count  = r_frame_count;

endmodule

// File: tb/tb_config_stream_loader.sv
// Directed bench for config_stream_loader: a WRITE_CYCLES=1 instance and a WRITE_CYCLES=3 instance, used one at a time.
module tb_config_stream_loader;
  localparam int WC1 = 1;
  localparam int WC3 = 3;
`ifdef CFG_CHECKSUM_EN
  localparam int FB = 9;
`else
  localparam int FB = 8;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1_n, rst3_n, sel;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        r1_ready, r1_write, r1_done, r3_ready, r3_write, r3_done;
  logic [31:0] r1_addr, r1_data, r3_addr, r3_data;
  logic [15:0] r1_fc, r3_fc;
  logic [7:0]  r1_ec, r3_ec;

  config_stream_loader #(.IDLE_ADDR(32'h0), .WRITE_CYCLES(WC1)) u_dut1 (
    .clk(clk), .reset(rst1_n), .in_data(in_data), .in_valid(in_valid), .in_ready(r1_ready),
    .config_addr(r1_addr), .config_data(r1_data), .config_write(r1_write), .config_done(r1_done),
    .frame_count(r1_fc), .err_count(r1_ec));

  config_stream_loader #(.IDLE_ADDR(32'h0), .WRITE_CYCLES(WC3)) u_dut3 (
    .clk(clk), .reset(rst3_n), .in_data(in_data), .in_valid(in_valid), .in_ready(r3_ready),
    .config_addr(r3_addr), .config_data(r3_data), .config_write(r3_write), .config_done(r3_done),
    .frame_count(r3_fc), .err_count(r3_ec));

  logic        m_ready, m_write, m_done;
  logic [31:0] m_addr, m_data;
  logic [15:0] m_fc;
  logic [7:0]  m_ec;
  assign m_ready = sel ? r3_ready : r1_ready;
  assign m_write = sel ? r3_write : r1_write;
  assign m_done  = sel ? r3_done  : r1_done;
  assign m_addr  = sel ? r3_addr  : r1_addr;
  assign m_data  = sel ? r3_data  : r1_data;
  assign m_fc    = sel ? r3_fc    : r1_fc;
  assign m_ec    = sel ? r3_ec    : r1_ec;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [63:0] sb_q[$];
  int          rise_q[$];
  logic [7:0]  fb [0:8];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void build(input logic [31:0] a, input logic [31:0] d, input bit bad);
    logic [7:0] cs;
    fb[0] = a[7:0];   fb[1] = a[15:8];  fb[2] = a[23:16]; fb[3] = a[31:24];
    fb[4] = d[7:0];   fb[5] = d[15:8];  fb[6] = d[23:16]; fb[7] = d[31:24];
    cs = 8'h00;
    for (int i = 0; i < 8; i++) cs = cs ^ fb[i];
    fb[8] = bad ? ~cs : cs;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (m_ready !== 1'b1 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("in_ready_handshake", 64'(m_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i < hi; i++) send_byte(fb[i]);
  endtask

  task automatic send_frame(input logic [31:0] a, input logic [31:0] d, input bit expect_write);
    build(a, d, 1'b0);
    if (expect_write) sb_q.push_back({a, d});
    send_range(0, FB);
  endtask

  task automatic monitor();
    logic        prev = 1'b0;
    int          len  = 0;
    logic [63:0] exp  = '0;
    forever begin
      @(negedge clk);
      if (m_write === 1'b1) begin
        if (!prev) begin
          rise_q.push_back(cyc);
          chk("scoreboard_has_entry", 64'(sb_q.size() > 0), 64'(1));
          exp = (sb_q.size() > 0) ? sb_q.pop_front() : {m_addr, m_data};
          len = 0;
        end
        chk("write_bus", {m_addr, m_data}, exp);
        chk("ready_low_in_write", 64'(m_ready), 64'(0));
        len++;
      end else begin
        if (prev) chk("pulse_len", 64'(len), 64'(sel ? WC3 : WC1));
        chk("idle_addr", 64'(m_addr), 64'(0));
      end
      prev = (m_write === 1'b1);
    end
  endtask

  initial begin
    sel = 1'b0; rst1_n = 1'b0; rst3_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(m_ready), 64'(0));
    chk("rst_write", 64'(m_write), 64'(0));
    chk("rst_addr",  64'(m_addr),  64'(0));
    chk("rst_data",  64'(m_data),  64'(0));
    chk("rst_done",  64'(m_done),  64'(0));
    chk("rst_fc",    64'(m_fc),    64'(0));
    chk("rst_ec",    64'(m_ec),    64'(0));
    rst1_n = 1'b1;
    #1;
    chk("ready_before_edge", 64'(m_ready), 64'(0));
    @(posedge clk); #1;
    chk("ready_after_edge", 64'(m_ready), 64'(1));

    // Basic frame
    send_frame(32'h0000_0001, 32'hDEAD_BEEF, 1'b1);
    repeat (3) @(posedge clk); #1;
    chk("t1_fc",    64'(m_fc),    64'(1));
    chk("t1_data",  64'(m_data),  64'(32'hDEAD_BEEF));
    chk("t1_ready", 64'(m_ready), 64'(1));

    // Five-cycle valid gap after byte 3
    build(32'h0000_0001, 32'hDEAD_BEEF, 1'b0);
    sb_q.push_back({32'h0000_0001, 32'hDEAD_BEEF});
    send_range(0, 4);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("gap_ready", 64'(m_ready), 64'(1));
    end
    send_range(4, FB);
    chk("gap_write_next_cycle", 64'(m_write), 64'(1));
    repeat (3) @(posedge clk); #1;
    chk("t2_fc", 64'(m_fc), 64'(2));

`ifdef CFG_CHECKSUM_EN
    build(32'h0000_0001, 32'hDEAD_BEEF, 1'b1);
    send_range(0, FB);
    chk("bad_cs_ready", 64'(m_ready), 64'(1));
    repeat (3) @(posedge clk); #1;
    chk("bad_cs_ec", 64'(m_ec), 64'(1));
    chk("bad_cs_fc", 64'(m_fc), 64'(2));
    send_frame(32'h0000_0002, 32'h0BAD_F00D, 1'b1);
    repeat (3) @(posedge clk); #1;
    chk("after_bad_fc", 64'(m_fc), 64'(3));
    chk("after_bad_ec", 64'(m_ec), 64'(1));
`endif

    // Reset during a write strobe drops it at once
    build(32'h0000_0003, 32'h5555_AAAA, 1'b0);
    send_range(0, FB);
    rst1_n = 1'b0;
    #1;
    chk("rst_mid_write", 64'(m_write), 64'(0));
    chk("rst_mid_write_fc", 64'(m_fc), 64'(0));
    @(posedge clk); #1;
    rst1_n = 1'b1;
    @(posedge clk); #1;

    // Reset after byte 5 discards the partial frame
    build(32'h0000_0009, 32'h1111_2222, 1'b0);
    send_range(0, 6);
    rst1_n = 1'b0;
    #1;
    chk("rst_mid_frame_ready", 64'(m_ready), 64'(0));
    @(posedge clk); #1;
    rst1_n = 1'b1;
    @(posedge clk); #1;
    send_frame(32'h0001_0002, 32'h1234_5678, 1'b1);
    repeat (3) @(posedge clk); #1;
    chk("after_rst_fc",   64'(m_fc),   64'(1));
    chk("after_rst_data", 64'(m_data), 64'(32'h1234_5678));

    // Terminator
    send_frame(32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
    chk("term_done",  64'(m_done),  64'(1));
    chk("term_ready", 64'(m_ready), 64'(0));
    chk("term_write", 64'(m_write), 64'(0));
    in_valid = 1'b1; in_data = 8'hAA;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("done_ignores_bytes", 64'(m_ready), 64'(0));
    end
    in_valid = 1'b0;
    chk("term_fc",     64'(m_fc),   64'(1));
    chk("done_sticky", 64'(m_done), 64'(1));

    // Second instance: three-cycle strobes, back-to-back frames
    rst1_n = 1'b0;
    sel    = 1'b1;
    @(posedge clk); #1;
    rst3_n = 1'b1;
    @(posedge clk); #1;
    rise_q.delete();
    send_frame(32'h0000_0010, 32'hCAFE_0001, 1'b1);
    send_frame(32'h0000_0020, 32'hCAFE_0002, 1'b1);
    repeat (8) @(posedge clk); #1;
    chk("wc3_rises", 64'(rise_q.size()), 64'(2));
    if (rise_q.size() == 2)
      chk("wc3_period", 64'(rise_q[1] - rise_q[0]), 64'(FB + WC3));
    chk("wc3_fc",    64'(m_fc),       64'(2));
    chk("wc3_data",  64'(m_data),     64'(32'hCAFE_0002));
    chk("sb_drained", 64'(sb_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
